// File: rtl/risc_v_core_pkg.sv
// Shared front-end types: 16-bit instruction parcels and the RVC length rule.
package risc_v_core_pkg;

    localparam int PARCEL_W = 16;

    typedef logic [PARCEL_W-1:0] parcel_t;

    // All-zero parcels are decoded as 32-bit so that they reach decode as illegal.
    function automatic logic is_rvc(parcel_t p);
        return (p[1:0] != 2'b11) && (p != '0);
    endfunction

endpackage

// File: rtl/fetch_parcel_fifo.sv
// Circular 16-bit parcel buffer: PUSH_N-wide push from a start offset, pop of 1 or 2, flush.
// Latency: pushed parcels are visible at head the next cycle; no internal backpressure.
module fetch_parcel_fifo
    import risc_v_core_pkg::*;
#(
    parameter int DEPTH  = 6,
    parameter int PUSH_N = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int SW    = (PUSH_N > 1) ? $clog2(PUSH_N) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [SW-1:0]                push_start,
    input  logic [PUSH_N*PARCEL_W-1:0]   push_data,
    input  logic                         pop,
    input  logic                         pop_two,
    output logic [CW-1:0]                count,
    output parcel_t                      head0,
    output parcel_t                      head1
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_S = (CW + 1)'(DEPTH);

    parcel_t        mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  push_cnt;
    logic [CW-1:0]  pop_cnt;

    // Modulo-DEPTH add; off never exceeds DEPTH so one conditional subtract suffices.
    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] base, logic [CW-1:0] off);
        logic [CW:0] s;
        s = {{(CW + 1 - PW){1'b0}}, base} + {1'b0, off};
        if (s >= DEPTH_S) begin
            s = s - DEPTH_S;
        end
        return s[PW-1:0];
    endfunction

    always_comb begin
        push_cnt = '0;
        pop_cnt  = '0;
        if (push) begin
            push_cnt = CW'(PUSH_N) - CW'(push_start);
        end
        if (pop) begin
            pop_cnt = pop_two ? CW'(2) : CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= wrap_add(rd_ptr, pop_cnt);
            wr_ptr <= wrap_add(wr_ptr, push_cnt);
            cnt    <= cnt + push_cnt - pop_cnt;
        end
    end

    // Parcels below push_start are skipped; the rest pack contiguously from wr_ptr.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int i = 0; i < PUSH_N; i++) begin
                if (i >= int'(push_start)) begin
                    mem[wrap_add(wr_ptr, CW'(i) - CW'(push_start))] <= push_data[i*PARCEL_W +: PARCEL_W];
                end
            end
        end
    end

    assign count = cnt;
    assign head0 = mem[rd_ptr];
    assign head1 = mem[wrap_add(rd_ptr, CW'(1))];

endmodule

// File: rtl/fetch_align_pc.sv
// Fetch alignment and PC tracking: splits fetch words into parcels, emits aligned RVC/32-bit instrs.
// Latency: word pushed in cycle N yields its first instruction in N+1; fetch_ready drops when a full word no longer fits.
module fetch_align_pc
    import risc_v_core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              FETCH_W     = 32,
    parameter int              BUF_PARCELS = 6,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [XLEN-1:0]    fetch_addr,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [FETCH_W-1:0] fetch_data,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [XLEN-1:0]    instr_pc,
    output logic               instr_is_rvc
);

    localparam int PUSH_N = FETCH_W / PARCEL_W;
    localparam int BYTES  = FETCH_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int DROP_W = OFF_W - 1;
    localparam int CW     = $clog2(BUF_PARCELS + 1);

    localparam logic [XLEN-1:0] HALF_MASK  = {{(XLEN - 1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    logic [CW-1:0]     count;
    parcel_t           head0;
    parcel_t           head1;
    logic              need_two;
    logic              do_push;
    logic              do_pop;
    logic              do_flush;
    logic [DROP_W-1:0] drop_cnt;

    fetch_parcel_fifo #(
        .DEPTH  (BUF_PARCELS),
        .PUSH_N (PUSH_N)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (do_flush),
        .push       (do_push),
        .push_start (drop_cnt),
        .push_data  (fetch_data),
        .pop        (do_pop),
        .pop_two    (need_two),
        .count      (count),
        .head0      (head0),
        .head1      (head1)
    );

    // Handshakes look only at registered occupancy, never at same-cycle pops.
    always_comb begin
        need_two     = !is_rvc(head0);
        instr_valid  = need_two ? (count >= CW'(2)) : (count != '0);
        fetch_ready  = (CW'(BUF_PARCELS) - count) >= CW'(PUSH_N);
        instr_is_rvc = instr_valid && !need_two;
        instr        = '0;
        if (instr_valid) begin
            instr = need_two ? {head1, head0} : {16'h0000, head0};
        end
        do_flush = enable && redirect;
        do_push  = fetch_valid && fetch_ready && enable && !redirect;
        do_pop   = instr_valid && instr_ready && enable && !redirect;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_addr <= RESET_PC;
            instr_pc   <= RESET_PC;
            drop_cnt   <= '0;
        end else if (do_flush) begin
            fetch_addr <= redirect_pc & ALIGN_MASK;
            instr_pc   <= redirect_pc & HALF_MASK;
            drop_cnt   <= redirect_pc[OFF_W-1:1];
        end else begin
            if (do_push) begin
                fetch_addr <= fetch_addr + XLEN'(BYTES);
                drop_cnt   <= '0;
            end
            if (do_pop) begin
                instr_pc <= instr_pc + (need_two ? XLEN'(4) : XLEN'(2));
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_pc.sv
// Directed bench for fetch_align_pc: a 32-bit-fetch instance (a) and a 64-bit-fetch instance (b)
// share clock, reset and enable; emitted instructions are checked against per-instance queues.
module tb_fetch_align_pc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;

    logic [31:0] fetch_addr_a, fetch_data_a, redirect_pc_a, instr_a, instr_pc_a;
    logic        fetch_valid_a, fetch_ready_a, redirect_a, instr_valid_a, instr_ready_a, instr_is_rvc_a;

    logic [31:0] fetch_addr_b, redirect_pc_b, instr_b, instr_pc_b;
    logic [63:0] fetch_data_b;
    logic        fetch_valid_b, fetch_ready_b, redirect_b, instr_valid_b, instr_ready_b, instr_is_rvc_b;

    fetch_align_pc #(.XLEN(32), .FETCH_W(32), .BUF_PARCELS(6), .RESET_PC(32'h8000_0000)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .fetch_addr(fetch_addr_a), .fetch_valid(fetch_valid_a), .fetch_ready(fetch_ready_a),
        .fetch_data(fetch_data_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .instr_valid(instr_valid_a), .instr_ready(instr_ready_a), .instr(instr_a),
        .instr_pc(instr_pc_a), .instr_is_rvc(instr_is_rvc_a)
    );

    fetch_align_pc #(.XLEN(32), .FETCH_W(64), .BUF_PARCELS(8), .RESET_PC(32'h8000_0000)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .fetch_addr(fetch_addr_b), .fetch_valid(fetch_valid_b), .fetch_ready(fetch_ready_b),
        .fetch_data(fetch_data_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready_b), .instr(instr_b),
        .instr_pc(instr_pc_b), .instr_is_rvc(instr_is_rvc_b)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rvc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare any handshake that fires this cycle, then advance to just after the next edge.
    task automatic step();
        exp_t e;
        if (instr_valid_a && instr_ready_a && enable && !redirect_a) begin
            chk("a_output_expected", 72'(sb_a.size() > 0), 72'd1);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                chk("a_instr_pc_rvc", 72'({instr_a, instr_pc_a, instr_is_rvc_a}), 72'(e));
            end
        end
        if (instr_valid_b && instr_ready_b && enable && !redirect_b) begin
            chk("b_output_expected", 72'(sb_b.size() > 0), 72'd1);
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                chk("b_instr_pc_rvc", 72'({instr_b, instr_pc_b, instr_is_rvc_b}), 72'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid_a = 1'b0; fetch_data_a = '0; redirect_a = 1'b0; redirect_pc_a = '0; instr_ready_a = 1'b0;
        fetch_valid_b = 1'b0; fetch_data_b = '0; redirect_b = 1'b0; redirect_pc_b = '0; instr_ready_b = 1'b0;
    endtask

    task automatic do_reset();
        chk("a_queue_drained", 72'(sb_a.size()), 72'd0);
        chk("b_queue_drained", 72'(sb_b.size()), 72'd0);
        sb_a.delete();
        sb_b.delete();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetch_addr", 72'(fetch_addr_a), 72'h8000_0000);
        chk("rst_instr_pc", 72'(instr_pc_a), 72'h8000_0000);
        chk("rst_instr_valid", 72'(instr_valid_a), 72'd0);
        chk("rst_instr", 72'(instr_a), 72'd0);
        chk("rst_is_rvc", 72'(instr_is_rvc_a), 72'd0);
        chk("rst_fetch_ready", 72'(fetch_ready_a), 72'd1);
        chk("rst_b_fetch_addr", 72'(fetch_addr_b), 72'h8000_0000);
        reset  = 1'b1;
        enable = 1'b1;
        step();

        // Two identical 32-bit instructions, one per fetch word.
        instr_ready_a = 1'b1;
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0013_0413;
        chk("t1_fetch_addr0", 72'(fetch_addr_a), 72'h8000_0000);
        sb_a.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0000, rvc: 1'b0});
        step();
        chk("t1_latency_valid", 72'(instr_valid_a), 72'd1);
        chk("t1_fetch_addr1", 72'(fetch_addr_a), 72'h8000_0004);
        sb_a.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0004, rvc: 1'b0});
        step();
        fetch_valid_a = 1'b0;
        repeat (2) step();
        chk("t1_fetch_addr_end", 72'(fetch_addr_a), 72'h8000_0008);
        chk("t1_instr_pc_end", 72'(instr_pc_a), 72'h8000_0008);
        chk("t1_empty", 72'(instr_valid_a), 72'd0);

        // Two RVC instructions in one word.
        do_reset();
        instr_ready_a = 1'b1;
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h4505_0505;
        sb_a.push_back(exp_t'{instr: 32'h0000_0505, pc: 32'h8000_0000, rvc: 1'b1});
        sb_a.push_back(exp_t'{instr: 32'h0000_4505, pc: 32'h8000_0002, rvc: 1'b1});
        step();
        fetch_valid_a = 1'b0;
        repeat (3) step();
        chk("t2_instr_pc_end", 72'(instr_pc_a), 72'h8000_0004);

        // 32-bit instruction straddling two fetch words.
        do_reset();
        instr_ready_a = 1'b1;
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0513_4505;
        sb_a.push_back(exp_t'{instr: 32'h0000_4505, pc: 32'h8000_0000, rvc: 1'b1});
        step();
        fetch_valid_a = 1'b0;
        step();
        chk("t3_wait_valid0", 72'(instr_valid_a), 72'd0);
        chk("t3_wait_instr0", 72'(instr_a), 72'd0);
        chk("t3_wait_pc", 72'(instr_pc_a), 72'h8000_0002);
        step();
        chk("t3_wait_valid1", 72'(instr_valid_a), 72'd0);
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0001_0000;
        chk("t3_fetch_addr_w1", 72'(fetch_addr_a), 72'h8000_0004);
        sb_a.push_back(exp_t'{instr: 32'h0000_0513, pc: 32'h8000_0002, rvc: 1'b0});
        sb_a.push_back(exp_t'{instr: 32'h0000_0001, pc: 32'h8000_0006, rvc: 1'b1});
        step();
        fetch_valid_a = 1'b0;
        repeat (3) step();
        chk("t3_instr_pc_end", 72'(instr_pc_a), 72'h8000_0008);

        // 64-bit fetch: redirect colliding with a push and a pop, then a dropped leading parcel.
        do_reset();
        fetch_valid_b = 1'b1;
        fetch_data_b  = 64'h0001_0001_4505_0505;
        sb_b.push_back(exp_t'{instr: 32'h0000_0505, pc: 32'h8000_0000, rvc: 1'b1});
        step();
        fetch_valid_b = 1'b0;
        instr_ready_b = 1'b1;
        step();
        redirect_b    = 1'b1;
        redirect_pc_b = 32'h8000_0102;
        fetch_valid_b = 1'b1;
        fetch_data_b  = 64'h0001_0001_0001_0001;
        chk("t4_pop_pending", 72'(instr_valid_b), 72'd1);
        step();
        redirect_b    = 1'b0;
        fetch_valid_b = 1'b0;
        chk("t4_fetch_addr", 72'(fetch_addr_b), 72'h8000_0100);
        chk("t4_instr_pc", 72'(instr_pc_b), 72'h8000_0102);
        chk("t4_flushed", 72'(instr_valid_b), 72'd0);
        chk("t4_fetch_ready", 72'(fetch_ready_b), 72'd1);
        fetch_valid_b = 1'b1;
        fetch_data_b  = 64'h0013_0413_0001_FFFF;
        sb_b.push_back(exp_t'{instr: 32'h0000_0001, pc: 32'h8000_0102, rvc: 1'b1});
        sb_b.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0104, rvc: 1'b0});
        step();
        fetch_valid_b = 1'b0;
        chk("t4_fetch_addr_next", 72'(fetch_addr_b), 72'h8000_0108);
        repeat (3) step();
        chk("t4_instr_pc_end", 72'(instr_pc_b), 72'h8000_0108);

        // Backpressure until full, then enable low freezes everything including a redirect.
        do_reset();
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0013_0413;
        sb_a.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0000, rvc: 1'b0});
        sb_a.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0004, rvc: 1'b0});
        sb_a.push_back(exp_t'{instr: 32'h0013_0413, pc: 32'h8000_0008, rvc: 1'b0});
        repeat (3) step();
        chk("t5_full_ready", 72'(fetch_ready_a), 72'd0);
        chk("t5_full_addr", 72'(fetch_addr_a), 72'h8000_000C);
        repeat (2) step();
        chk("t5_hold_ready", 72'(fetch_ready_a), 72'd0);
        chk("t5_hold_addr", 72'(fetch_addr_a), 72'h8000_000C);
        enable        = 1'b0;
        instr_ready_a = 1'b1;
        redirect_a    = 1'b1;
        redirect_pc_a = 32'h0000_1234;
        repeat (2) step();
        chk("t5_frozen_addr", 72'(fetch_addr_a), 72'h8000_000C);
        chk("t5_frozen_pc", 72'(instr_pc_a), 72'h8000_0000);
        chk("t5_frozen_valid", 72'(instr_valid_a), 72'd1);
        chk("t5_frozen_instr", 72'(instr_a), 72'h0013_0413);
        redirect_a    = 1'b0;
        fetch_valid_a = 1'b0;
        enable        = 1'b1;
        repeat (4) step();
        chk("t5_instr_pc_end", 72'(instr_pc_a), 72'h8000_000C);

        // Asynchronous reset with the low half of a 32-bit instruction buffered.
        do_reset();
        instr_ready_a = 1'b1;
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0513_4505;
        sb_a.push_back(exp_t'{instr: 32'h0000_4505, pc: 32'h8000_0000, rvc: 1'b1});
        step();
        fetch_valid_a = 1'b0;
        step();
        chk("t6_partial_wait", 72'(instr_valid_a), 72'd0);
        chk("t6_pc_before", 72'(instr_pc_a), 72'h8000_0002);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", 72'(instr_valid_a), 72'd0);
        chk("t6_async_fetch_addr", 72'(fetch_addr_a), 72'h8000_0000);
        chk("t6_async_instr_pc", 72'(instr_pc_a), 72'h8000_0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        fetch_valid_a = 1'b1;
        fetch_data_a  = 32'h0001_0001;
        sb_a.push_back(exp_t'{instr: 32'h0000_0001, pc: 32'h8000_0000, rvc: 1'b1});
        sb_a.push_back(exp_t'{instr: 32'h0000_0001, pc: 32'h8000_0002, rvc: 1'b1});
        step();
        fetch_valid_a = 1'b0;
        repeat (3) step();

        chk("end_a_drained", 72'(sb_a.size()), 72'd0);
        chk("end_b_drained", 72'(sb_b.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
